// File: rtl/child_rr_scheduler.sv
// Round-robin scheduler granting one child at a time. A grant is held until
// the grantee's done strobe or until the watchdog revokes it.
module child_rr_scheduler #(
  parameter int NUM_REQ     = 5,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] grant,
  output logic [2:0]         grant_id,
  output logic               busy,
  output logic               timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);
  localparam logic [3:0] NUM_REQ4 = 4'(NUM_REQ);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [2:0]         id_q, id_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               timeout_q, timeout_d;

  logic [7:0]         req_ext;
  logic [3:0]         cand;
  logic [2:0]         win;
  logic               found;
  logic [NUM_REQ-1:0] win_onehot;

  // Search starts one past the last winner and wraps, so the last grantee
  // always has the lowest priority in the next round.
  always_comb begin
    req_ext = 8'(req);
    cand    = '0;
    win     = '0;
    found   = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + 4'(i);
      if (cand >= NUM_REQ4) cand = cand - NUM_REQ4;
      if (!found && req_ext[cand[2:0]]) begin
        found = 1'b1;
        win   = cand[2:0];
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      win_onehot[j] = (3'(j) == win);
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          grant_d = win_onehot;
          id_d    = win;
          ptr_d   = win;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        // done from the grantee wins over a watchdog expiry in the same cycle
        if (|(done & grant_q)) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          grant_d   = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      id_q      <= '0;
      ptr_q     <= 3'(NUM_REQ - 1);
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = id_q;
  assign busy     = (state_q == GRANT);
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_child_rr_scheduler.sv
// Bench for child_rr_scheduler: directed scenarios followed by random traffic,
// every cycle compared against a grant-length/owner reference model.
module tb_child_rr_scheduler;

  localparam int N = 5;
  localparam int T = 16;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] done;
  logic [N-1:0] grant;
  logic [2:0]   grant_id;
  logic         busy;
  logic         timeout;

  int tests = 0;
  int fails = 0;

  // reference model: owner index (-1 when nobody holds the resource),
  // cycles the current owner has held it, last owner, last winner
  int m_owner = -1;
  int m_age   = 0;
  int m_id    = 0;
  int m_ptr   = N - 1;
  bit m_to    = 1'b0;

  child_rr_scheduler #(.NUM_REQ(N), .TIMEOUT_CYC(T)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic void model_edge(input logic r_rst, input logic [N-1:0] r_req,
                                     input logic [N-1:0] r_done);
    m_to = 1'b0;
    if (r_rst) begin
      m_owner = -1;
      m_age   = 0;
      m_id    = 0;
      m_ptr   = N - 1;
    end else if (m_owner < 0) begin
      if (r_req != '0) begin
        m_owner = rr_pick(r_req, m_ptr);
        m_ptr   = m_owner;
        m_id    = m_owner;
        m_age   = 1;
      end
    end else if (r_done[m_owner]) begin
      m_owner = -1;
    end else if (m_age == T) begin
      m_owner = -1;
      m_to    = 1'b1;
    end else begin
      m_age++;
    end
  endfunction

  // one clock: inputs are stable from before the edge, outputs checked 1ns after
  task automatic tick();
    logic         s_rst;
    logic [N-1:0] s_req;
    logic [N-1:0] s_done;
    logic [7:0]   exp_g;
    s_rst  = rst;
    s_req  = req;
    s_done = done;
    @(posedge clk);
    model_edge(s_rst, s_req, s_done);
    #1;
    exp_g = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
    check("model_grant", 8'(grant), exp_g);
    check("model_grant_id", 8'(grant_id), 8'(m_id));
    check("model_busy", 8'(busy), (m_owner < 0) ? 8'h00 : 8'h01);
    check("model_timeout", 8'(timeout), 8'(m_to));
    check("grant_onehot0", 8'($onehot0(grant)), 8'h01);
  endtask

  task automatic expect_out(input string tag, input logic [N-1:0] g, input logic [2:0] id,
                            input logic b, input logic to);
    check({tag, "_grant"}, 8'(grant), 8'(g));
    check({tag, "_id"}, 8'(grant_id), 8'(id));
    check({tag, "_busy"}, 8'(busy), 8'(b));
    check({tag, "_timeout"}, 8'(timeout), 8'(to));
  endtask

  initial begin
    rst  = 1'b1;
    req  = 5'b11111;
    done = 5'b11111;
    tick();
    tick();
    expect_out("reset", 5'b00000, 3'd0, 1'b0, 1'b0);

    rst  = 1'b0;
    req  = 5'b10101;
    done = 5'b00000;
    tick();
    expect_out("first_grant", 5'b00001, 3'd0, 1'b1, 1'b0);

    done = 5'b00001;
    tick();
    expect_out("release0_idle", 5'b00000, 3'd0, 1'b0, 1'b0);
    done = 5'b00000;
    tick();
    expect_out("rr_child2", 5'b00100, 3'd2, 1'b1, 1'b0);
    done = 5'b00100;
    tick();
    done = 5'b00000;
    tick();
    expect_out("rr_child4", 5'b10000, 3'd4, 1'b1, 1'b0);
    done = 5'b10000;
    tick();
    expect_out("release4_hold_id", 5'b00000, 3'd4, 1'b0, 1'b0);
    done = 5'b00000;
    tick();
    expect_out("rr_wrap0", 5'b00001, 3'd0, 1'b1, 1'b0);

    done = 5'b00001;
    req  = 5'b00000;
    tick();
    done = 5'b00000;
    tick();

    // watchdog: child 2 drops req without done, grant held until expiry
    req = 5'b00100;
    tick();
    expect_out("wd_grant2", 5'b00100, 3'd2, 1'b1, 1'b0);
    req = 5'b00000;
    for (int i = 1; i < T; i++) tick();
    expect_out("wd_last_cycle", 5'b00100, 3'd2, 1'b1, 1'b0);
    tick();
    expect_out("wd_expire", 5'b00000, 3'd2, 1'b0, 1'b1);
    tick();
    expect_out("wd_pulse_end", 5'b00000, 3'd2, 1'b0, 1'b0);

    // foreign done ignored, then done exactly on the expiry cycle
    req = 5'b01000;
    tick();
    expect_out("grant3", 5'b01000, 3'd3, 1'b1, 1'b0);
    req = 5'b00000;
    for (int i = 1; i < T; i++) begin
      done = (i == 5) ? 5'b00010 : 5'b00000;
      tick();
    end
    expect_out("foreign_done_ignored", 5'b01000, 3'd3, 1'b1, 1'b0);
    done = 5'b01000;
    tick();
    expect_out("done_beats_wd", 5'b00000, 3'd3, 1'b0, 1'b0);
    done = 5'b00000;
    tick();
    expect_out("no_late_timeout", 5'b00000, 3'd3, 1'b0, 1'b0);

    // reset in the middle of a grant
    req = 5'b00001;
    tick();
    expect_out("pre_rst_grant0", 5'b00001, 3'd0, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    expect_out("mid_grant_rst", 5'b00000, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    req = 5'b11111;
    tick();
    expect_out("post_rst_child0", 5'b00001, 3'd0, 1'b1, 1'b0);
    done = 5'b00001;
    req  = 5'b00000;
    tick();
    done = 5'b00000;
    tick();

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 249) == 0);
      req = 5'($urandom_range(0, 31));
      if ((c / 300) % 2 == 0)
        done = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'b00000;
      else
        done = ($urandom_range(0, 40) == 0) ? 5'($urandom_range(0, 31)) : 5'b00000;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
